// File: rtl/uart_reg_master.sv
// uart_reg_master: register-bus initiator over the UART packet stream.
// Serialises one read/write command into a command packet and, for reads,
// parses the matching response packet back into a data word.
// Optional feature macro: REG_MASTER_TIMEOUT_EN adds a read-response
// timeout (TIMEOUT_CYCLES) and drives opRspTimeout; without it the
// timeout output is tied low and a read waits until a response or reset.
module uart_reg_master #(
    parameter int         DATA_WIDTH  = 32,
    parameter logic [7:0] DESTINATION = 8'h01,
    parameter logic [7:0] SOURCE      = 8'h00
`ifdef REG_MASTER_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  logic                  ipCmdValid,
    input  logic                  ipCmdWrite,
    input  logic [7:0]            ipCmdAddress,
    input  logic [DATA_WIDTH-1:0] ipCmdData,
    output logic                  opCmdReady,
    output logic                  opTxValid,
    output logic                  opTxSoP,
    output logic                  opTxEoP,
    output logic [7:0]            opTxSource,
    output logic [7:0]            opTxDestination,
    output logic [7:0]            opTxLength,
    output logic [7:0]            opTxData,
    input  logic                  ipTxReady,
    input  logic                  ipRxValid,
    input  logic                  ipRxSoP,
    input  logic                  ipRxEoP,
    input  logic [7:0]            ipRxSource,
    input  logic [7:0]            ipRxDestination,
    input  logic [7:0]            ipRxLength,
    input  logic [7:0]            ipRxData,
    output logic                  opRspValid,
    output logic [DATA_WIDTH-1:0] opRspData,
    output logic                  opRspTimeout
);

    localparam int         NB      = DATA_WIDTH / 8;
    localparam logic [3:0] LAST    = 4'(NB - 1);
    localparam logic [7:0] WR_LEN  = 8'(2 + NB);
    localparam logic [7:0] RD_LEN  = 8'd2;
    localparam logic [7:0] RSP_LEN = 8'(1 + NB);

    typedef enum logic [2:0] {
        IDLE, SEND_OP, SEND_ADDR, SEND_DATA, WAIT_RSP, RECV
    } state_t;

    state_t                  state;
    logic                    is_write;
    logic [7:0]              addr;
    logic [DATA_WIDTH-1:0]   wdata;     // write data, shifted out LSB first
    logic [DATA_WIDTH-1:0]   rshift;    // read data, shifted in from the top
    logic [3:0]              idx;       // data byte index within a packet
    logic                    tx_hs;
    logic                    hdr_ok;
    logic [DATA_WIDTH+7:0]   rx_cat;
    logic [DATA_WIDTH-1:0]   rx_next;
    logic                    unused_rx_source;

    // The responder's source address is not needed to match a response.
    assign unused_rx_source = ^ipRxSource;

    assign tx_hs   = opTxValid & ipTxReady;
    // Little-endian assembly: each new byte enters at the top and the word
    // slides down, so after NB bytes the first byte sits in bits [7:0].
    assign rx_cat  = {ipRxData, rshift};
    assign rx_next = rx_cat[DATA_WIDTH+7:8];
    // A response header byte must also not be the last byte, since a valid
    // response always carries NB data bytes after the address.
    assign hdr_ok  = ipRxValid & ipRxSoP & ~ipRxEoP &
                     (ipRxDestination == SOURCE) &
                     (ipRxLength == RSP_LEN) &
                     (ipRxData == addr);

`ifdef REG_MASTER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt;
    logic        rsp_done;
    // Completion in the same cycle as expiry takes priority over the timeout.
    assign rsp_done = (state == RECV) & ipRxValid & ~ipRxSoP & ipRxEoP & (idx == LAST);
`else
    assign opRspTimeout = 1'b0;
`endif

    // Command/response FSM with all outputs registered.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state           <= IDLE;
            opCmdReady      <= 1'b1;
            opTxValid       <= 1'b0;
            opTxSoP         <= 1'b0;
            opTxEoP         <= 1'b0;
            opTxSource      <= 8'h00;
            opTxDestination <= 8'h00;
            opTxLength      <= 8'h00;
            opTxData        <= 8'h00;
            opRspValid      <= 1'b0;
            opRspData       <= '0;
            is_write        <= 1'b0;
            addr            <= 8'h00;
            wdata           <= '0;
            rshift          <= '0;
            idx             <= 4'd0;
`ifdef REG_MASTER_TIMEOUT_EN
            tmo_cnt         <= 32'd0;
            opRspTimeout    <= 1'b0;
`endif
        end else begin
            opRspValid <= 1'b0;
`ifdef REG_MASTER_TIMEOUT_EN
            opRspTimeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ipCmdValid) begin
                        is_write        <= ipCmdWrite;
                        addr            <= ipCmdAddress;
                        wdata           <= ipCmdData;
                        opCmdReady      <= 1'b0;
                        opTxValid       <= 1'b1;
                        opTxSoP         <= 1'b1;
                        opTxEoP         <= 1'b0;
                        opTxSource      <= SOURCE;
                        opTxDestination <= DESTINATION;
                        opTxLength      <= ipCmdWrite ? WR_LEN : RD_LEN;
                        opTxData        <= {7'd0, ipCmdWrite};
                        state           <= SEND_OP;
                    end
                end
                SEND_OP: begin
                    if (tx_hs) begin
                        opTxData <= addr;
                        opTxSoP  <= 1'b0;
                        opTxEoP  <= ~is_write;
                        state    <= SEND_ADDR;
                    end
                end
                SEND_ADDR: begin
                    if (tx_hs) begin
                        if (is_write) begin
                            opTxData <= wdata[7:0];
                            wdata    <= wdata >> 8;
                            opTxEoP  <= (NB == 1);
                            idx      <= 4'd0;
                            state    <= SEND_DATA;
                        end else begin
                            opTxValid <= 1'b0;
                            opTxEoP   <= 1'b0;
                            state     <= WAIT_RSP;
`ifdef REG_MASTER_TIMEOUT_EN
                            tmo_cnt   <= 32'd0;
`endif
                        end
                    end
                end
                SEND_DATA: begin
                    if (tx_hs) begin
                        if (idx == LAST) begin
                            opTxValid  <= 1'b0;
                            opTxEoP    <= 1'b0;
                            opCmdReady <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            opTxData <= wdata[7:0];
                            wdata    <= wdata >> 8;
                            idx      <= idx + 4'd1;
                            opTxEoP  <= ((idx + 4'd1) == LAST);
                        end
                    end
                end
                WAIT_RSP: begin
                    // Non-SoP bytes (tails of rejected packets) never match.
                    if (hdr_ok) begin
                        idx   <= 4'd0;
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (ipRxValid) begin
                        if (ipRxSoP) begin
                            state <= WAIT_RSP;
                        end else begin
                            rshift <= rx_next;
                            if (idx == LAST) begin
                                if (ipRxEoP) begin
                                    opRspData  <= rx_next;
                                    opRspValid <= 1'b1;
                                    opCmdReady <= 1'b1;
                                    state      <= IDLE;
                                end else begin
                                    state <= WAIT_RSP;
                                end
                            end else if (ipRxEoP) begin
                                state <= WAIT_RSP;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef REG_MASTER_TIMEOUT_EN
            // Abandon a read that has not completed within the budget.
            if (state == WAIT_RSP || state == RECV) begin
                tmo_cnt <= tmo_cnt + 32'd1;
                if (tmo_cnt == TMO_LAST && !rsp_done) begin
                    opRspTimeout <= 1'b1;
                    opCmdReady   <= 1'b1;
                    state        <= IDLE;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_reg_master.sv
// Self-checking bench for uart_reg_master (DATA_WIDTH = 32).
// Table of write vectors plus hand-written read/reset sequences.
module tb_uart_reg_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        tx_valid, tx_sop, tx_eop;
    logic [7:0]  tx_src, tx_dst, tx_len, tx_data;
    logic        tx_ready;
    logic        rx_valid, rx_sop, rx_eop;
    logic [7:0]  rx_src, rx_dst, rx_len, rx_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  cap_b [16];
    logic [15:0] cap_sop, cap_eop;
    logic [7:0]  cap_len, cap_src, cap_dst;
    int          ncap;
    bit          saw_rsp;

    always #5 clk = ~clk;

    uart_reg_master #(
        .DATA_WIDTH(32)
`ifdef REG_MASTER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .ipClk(clk), .ipReset(rst),
        .ipCmdValid(cmd_valid), .ipCmdWrite(cmd_write),
        .ipCmdAddress(cmd_addr), .ipCmdData(cmd_data), .opCmdReady(cmd_ready),
        .opTxValid(tx_valid), .opTxSoP(tx_sop), .opTxEoP(tx_eop),
        .opTxSource(tx_src), .opTxDestination(tx_dst), .opTxLength(tx_len),
        .opTxData(tx_data), .ipTxReady(tx_ready),
        .ipRxValid(rx_valid), .ipRxSoP(rx_sop), .ipRxEoP(rx_eop),
        .ipRxSource(rx_src), .ipRxDestination(rx_dst), .ipRxLength(rx_len),
        .ipRxData(rx_data),
        .opRspValid(rsp_valid), .opRspData(rsp_data), .opRspTimeout(rsp_timeout)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp_len;
        int          exp_n;
        logic [47:0] exp_bytes;   // byte i at [8*i +: 8]
    } wvec_t;

    wvec_t vec [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Capture one Tx packet, optionally stalling every other cycle.
    task automatic collect(input bit toggle);
        int         cyc;
        bit         done, have_hold;
        logic [7:0] hold;
        cyc = 0; done = 0; have_hold = 0; hold = 8'h00;
        ncap = 0; cap_sop = '0; cap_eop = '0;
        while (!done && cyc < 100) begin
            tx_ready = toggle ? (cyc[0] == 1'b0) : 1'b1;
            if (have_hold) begin
                check("tx_hold_valid", 64'(tx_valid), 64'd1);
                check("tx_hold_data", 64'(tx_data), 64'(hold));
            end
            have_hold = 0;
            if (tx_valid) begin
                if (tx_ready) begin
                    if (ncap == 0) begin
                        cap_len = tx_len; cap_src = tx_src; cap_dst = tx_dst;
                    end
                    if (ncap < 16) begin
                        cap_b[ncap]   = tx_data;
                        cap_sop[ncap] = tx_sop;
                        cap_eop[ncap] = tx_eop;
                    end
                    ncap++;
                    if (tx_eop) done = 1;
                end else begin
                    have_hold = 1;
                    hold = tx_data;
                end
            end
            tick;
            cyc++;
        end
        tx_ready = 1'b1;
        if (!done) check("tx_eop_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit toggle);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin tick; w++; end
        if (!cmd_ready) check("cmd_ready_wait", 64'd0, 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
        tick;
        cmd_valid = 1'b0; cmd_data = '0; cmd_addr = 8'h00;
        check("first_byte_valid", 64'(tx_valid), 64'd1);
        check("first_byte_sop", 64'(tx_sop), 64'd1);
        check("ready_low_busy", 64'(cmd_ready), 64'd0);
        collect(toggle);
        check("tx_idle_after", 64'(tx_valid), 64'd0);
        check("ready_after_pkt", 64'(cmd_ready), 64'(wr));
    endtask

    task automatic rx_pkt(input logic [7:0] dst, input logic [7:0] len, input logic [7:0] a,
                          input logic [31:0] d, input int eop_at);
        for (int i = 0; i <= eop_at; i++) begin
            rx_valid = 1'b1;
            rx_sop   = (i == 0);
            rx_eop   = (i == eop_at);
            rx_src   = 8'h01;
            rx_dst   = dst;
            rx_len   = len;
            if (i == 0)      rx_data = a;
            else if (i <= 4) rx_data = d[8*(i-1) +: 8];
            else             rx_data = 8'h55;
            tick;
            if (rsp_valid) saw_rsp = 1;
        end
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{8'h05, 32'hDEADBEEF, 8'd6, 6, 48'hDEADBEEF_0501};
        vec[1] = '{8'hFF, 32'h00000001, 8'd6, 6, 48'h00000001_FF01};
        vec[2] = '{8'h00, 32'hA5A55A5A, 8'd6, 6, 48'hA5A55A5A_0001};
        vec[3] = '{8'h7F, 32'h80000000, 8'd6, 6, 48'h80000000_7F01};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_data = '0;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        rx_src = 8'h00; rx_dst = 8'h00; rx_len = 8'h00; rx_data = 8'h00; saw_rsp = 0;
        tick; tick;
        rst = 1'b0;
        tick;
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_len", 64'(tx_len), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);

        // Writes, back to back, all bytes and framing against the table.
        for (int v = 0; v < 4; v++) begin
            send_cmd(1'b1, vec[v].addr, vec[v].data, 1'b0);
            check("wr_count", 64'(ncap), 64'(vec[v].exp_n));
            check("wr_length", 64'(cap_len), 64'(vec[v].exp_len));
            check("wr_source", 64'(cap_src), 64'h00);
            check("wr_dest", 64'(cap_dst), 64'h01);
            check("wr_sop_mask", 64'(cap_sop), 64'h0001);
            check("wr_eop_mask", 64'(cap_eop), 64'(16'h1 << (vec[v].exp_n - 1)));
            for (int b = 0; b < vec[v].exp_n; b++)
                check("wr_byte", 64'(cap_b[b]), 64'(vec[v].exp_bytes[8*b +: 8]));
        end

        // Read with stalling Tx, then a good response.
        send_cmd(1'b0, 8'h10, 32'h0, 1'b1);
        check("rd_count", 64'(ncap), 64'd2);
        check("rd_length", 64'(cap_len), 64'd2);
        check("rd_byte0", 64'(cap_b[0]), 64'h00);
        check("rd_byte1", 64'(cap_b[1]), 64'h10);
        check("rd_eop_mask", 64'(cap_eop), 64'h2);
        saw_rsp = 0;
        rx_pkt(8'h00, 8'd5, 8'h10, 32'h12345678, 4);
        check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_data", 64'(rsp_data), 64'h12345678);
        tick;
        check("rd_rsp_pulse_end", 64'(rsp_valid), 64'd0);
        check("rd_ready_after", 64'(cmd_ready), 64'd1);

        // Read with mismatching responses ahead of the good one.
        send_cmd(1'b0, 8'h10, 32'h0, 1'b0);
        saw_rsp = 0;
        rx_pkt(8'h00, 8'd5, 8'h11, 32'hAAAAAAAA, 4);
        rx_pkt(8'h02, 8'd5, 8'h10, 32'hBBBBBBBB, 4);
        rx_pkt(8'h00, 8'd4, 8'h10, 32'hCCCCCCCC, 3);
        check("filt_no_rsp", 64'(saw_rsp), 64'd0);
        check("filt_data_held", 64'(rsp_data), 64'h12345678);
        check("filt_still_busy", 64'(cmd_ready), 64'd0);
        rx_pkt(8'h00, 8'd5, 8'h10, 32'hCAFEF00D, 4);
        check("filt_rsp_valid", 64'(rsp_valid), 64'd1);
        check("filt_rsp_data", 64'(rsp_data), 64'hCAFEF00D);

        // Early and late EoP are dropped; the next good packet completes.
        send_cmd(1'b0, 8'h20, 32'h0, 1'b0);
        saw_rsp = 0;
        rx_pkt(8'h00, 8'd5, 8'h20, 32'h11111111, 3);
        rx_pkt(8'h00, 8'd5, 8'h20, 32'h22222222, 5);
        check("eop_no_rsp", 64'(saw_rsp), 64'd0);
        rx_pkt(8'h00, 8'd5, 8'h20, 32'h0BADF00D, 4);
        check("eop_rsp_valid", 64'(rsp_valid), 64'd1);
        check("eop_rsp_data", 64'(rsp_data), 64'h0BADF00D);
        tick;

        // Reset in the middle of the data bytes truncates the packet.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_data = 32'h44332211;
        tx_ready = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick; tick; tick;
        check("mid_data_byte", 64'(tx_data), 64'h22);
        rst = 1'b1;
        tick;
        check("mid_rst_valid", 64'(tx_valid), 64'd0);
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;
        tick;
        send_cmd(1'b1, 8'h33, 32'h44332211, 1'b0);
        check("post_rst_count", 64'(ncap), 64'd6);
        check("post_rst_sop", 64'(cap_sop), 64'h1);
        check("post_rst_b0", 64'(cap_b[0]), 64'h01);
        check("post_rst_b1", 64'(cap_b[1]), 64'h33);
        check("post_rst_b2", 64'(cap_b[2]), 64'h11);
        check("post_rst_b5", 64'(cap_b[5]), 64'h44);

`ifdef REG_MASTER_TIMEOUT_EN
        begin
            int k;
            bit seen;
            send_cmd(1'b0, 8'h40, 32'h0, 1'b0);
            k = 0; seen = 0;
            while (!seen && k < 200) begin
                tick; k++;
                if (rsp_timeout) seen = 1;
            end
            check("tmo_cycles", 64'(k), 64'd100);
            check("tmo_data_held", 64'(rsp_data), 64'h0BADF00D);
            check("tmo_ready", 64'(cmd_ready), 64'd1);
            tick;
            check("tmo_pulse_end", 64'(rsp_timeout), 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
